led_bar_pwm: RTL



---
 rtl/led_bar_pwm.sv | 87 ++++++++
 1 files changed

// File: rtl/led_bar_pwm.sv
// PWM bar-graph driver for eight LEDs.
// Level is latched once per PWM period so the bar never glitches mid-period.
module led_bar_pwm #(
    parameter int PRESC = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] level,
    output logic [7:0] leds,
    output logic       period_start
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state;
    logic [PRESC-1:0] presc;
    logic [7:0]       phase;
    logic [7:0]       shadow;
    logic             tick;
    logic             wrap;
    logic [2:0]       k;
    logic [7:0]       thresh;
    logic [7:0]       bar;

    assign tick   = (presc == {PRESC{1'b1}});
    assign wrap   = tick && (phase == 8'hFF);
    assign k      = shadow[7:5];
    assign thresh = {shadow[4:0], 3'b000};

    // LEDs below k are solid, LED k carries the fractional duty
    always_comb begin
        bar = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (3'(i) < k)
                bar[i] = 1'b1;
            else if (3'(i) == k)
                bar[i] = (phase < thresh);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            presc        <= '0;
            phase        <= 8'h00;
            shadow       <= 8'h00;
            leds         <= 8'h00;
            period_start <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    presc <= '0;
                    phase <= 8'h00;
                    leds  <= 8'h00;
                    if (en) begin
                        state        <= RUN;
                        shadow       <= level;
                        period_start <= 1'b1;
                    end else begin
                        period_start <= 1'b0;
                    end
                end
                RUN: begin
                    if (!en) begin
                        state        <= IDLE;
                        presc        <= '0;
                        phase        <= 8'h00;
                        leds         <= 8'h00;
                        period_start <= 1'b0;
                    end else begin
                        presc        <= presc + 1'b1;
                        leds         <= bar;
                        period_start <= wrap;
                        if (tick)
                            phase <= phase + 8'd1;
                        if (wrap)
                            shadow <= level;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
